sobel_stream_arb: RTL and testbench



---
 rtl/sobel_pkg.sv | 27 ++
 rtl/frame_counter.sv | 33 +++
 rtl/sobel_stream_arb.sv | 145 ++++++++++++++
 tb/tb_sobel_stream_arb.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared definitions for the two-stream sobel arbiter: state codes, frame size
// helpers and the pixel-counter width check.
package sobel_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

    function automatic int clog2(input longint value);
        int r;
        r = 0;
        for (longint v = value - 1; v > 0; v = v >>> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic longint frame_pix(input int w, input int h);
        return longint'(w) * longint'(h);
    endfunction

    // 2^cw > pix  <=>  cw >= clog2(pix + 1)
    function automatic bit cnt_width_ok(input int cw, input longint pix);
        return clog2(pix + 1) <= cw;
    endfunction

endpackage

// File: rtl/frame_counter.sv
// Pixel counter for one frame: counts enabled events up to FRAME_PIX and holds there.
// `last` flags the event that reaches FRAME_PIX; `done` is the terminal-count flag.
module frame_counter #(
    parameter int CNT_WIDTH = 20,
    parameter int FRAME_PIX = 388800
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic last,
    output logic done
);

    localparam logic [CNT_WIDTH-1:0] TERM     = CNT_WIDTH'(FRAME_PIX);
    localparam logic [CNT_WIDTH-1:0] TERM_M1  = CNT_WIDTH'(FRAME_PIX - 1);

    logic [CNT_WIDTH-1:0] cnt;

    assign done = (cnt == TERM);
    assign last = en && (cnt == TERM_M1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en && !done) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sobel_stream_arb.sv
// Frame-granular round-robin arbiter sharing one sobel filter between two streams.
// Data/strobe paths are combinational muxes on registered src/state; frame_done is registered.
module sobel_stream_arb
    import sobel_pkg::*;
#(
    parameter int DWIDTH_IN  = 8,
    parameter int DWIDTH_OUT = 8,
    parameter int IMG_WIDTH  = 720,
    parameter int IMG_HEIGHT = 540,
    parameter int CNT_WIDTH  = 20
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  in0_rd_en,
    input  logic [DWIDTH_IN-1:0]  in0_dout,
    input  logic                  in0_empty,
    output logic                  in1_rd_en,
    input  logic [DWIDTH_IN-1:0]  in1_dout,
    input  logic                  in1_empty,
    input  logic                  filt_in_rd_en,
    output logic [DWIDTH_IN-1:0]  filt_in_dout,
    output logic                  filt_in_empty,
    input  logic                  filt_out_wr_en,
    input  logic [DWIDTH_OUT-1:0] filt_out_din,
    output logic                  filt_out_full,
    output logic                  out0_wr_en,
    output logic [DWIDTH_OUT-1:0] out0_din,
    input  logic                  out0_full,
    output logic                  out1_wr_en,
    output logic [DWIDTH_OUT-1:0] out1_din,
    input  logic                  out1_full,
    output logic                  src,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_src,
    output logic                  err
);

    localparam int FRAME_PIX = int'(frame_pix(IMG_WIDTH, IMG_HEIGHT));

    generate
        if (!cnt_width_ok(CNT_WIDTH, longint'(FRAME_PIX))) begin : g_cnt_width_check
            $error("CNT_WIDTH too small for IMG_WIDTH*IMG_HEIGHT");
        end
    endgenerate

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       src_nxt;
    logic       last_src;
    logic       streaming;
    logic       in_acc;
    logic       out_acc;
    logic       in_last;
    logic       in_done;
    logic       out_last;
    logic       out_done;
    logic       finish;

    // in_done guards against over-reading should the frame already be fully consumed.
    assign streaming = (state == ST_STREAM) && !in_done;
    assign busy      = (state == ST_STREAM) || (state == ST_DRAIN);

    assign filt_in_dout  = src ? in1_dout : in0_dout;
    assign filt_in_empty = streaming ? (src ? in1_empty : in0_empty) : 1'b1;
    assign in0_rd_en     = streaming && !src && filt_in_rd_en && !in0_empty;
    assign in1_rd_en     = streaming &&  src && filt_in_rd_en && !in1_empty;
    assign in_acc        = filt_in_rd_en && !filt_in_empty;

    assign out0_wr_en    = busy && !src && filt_out_wr_en;
    assign out1_wr_en    = busy &&  src && filt_out_wr_en;
    assign out0_din      = filt_out_din;
    assign out1_din      = filt_out_din;
    assign filt_out_full = busy ? (src ? out1_full : out0_full) : 1'b1;
    assign out_acc       = busy && filt_out_wr_en;

    frame_counter #(.CNT_WIDTH(CNT_WIDTH), .FRAME_PIX(FRAME_PIX)) u_in_cnt (
        .clock (clock),
        .reset (reset),
        .clear (state == ST_IDLE),
        .en    (in_acc),
        .last  (in_last),
        .done  (in_done)
    );

    frame_counter #(.CNT_WIDTH(CNT_WIDTH), .FRAME_PIX(FRAME_PIX)) u_out_cnt (
        .clock (clock),
        .reset (reset),
        .clear (state == ST_IDLE),
        .en    (out_acc),
        .last  (out_last),
        .done  (out_done)
    );

    // A filter that finishes writing early keeps us in STREAM until the input side completes.
    assign finish = ((state == ST_STREAM) && in_last && (out_done || out_last)) ||
                    ((state == ST_DRAIN) && out_last);

    always_comb begin
        state_nxt = state;
        src_nxt   = src;
        case (state)
            ST_IDLE: begin
                if (!in0_empty || !in1_empty) begin
                    state_nxt = ST_STREAM;
                    src_nxt   = (!in0_empty && !in1_empty) ? !last_src : in0_empty;
                end
            end
            ST_STREAM: begin
                if (in_last) begin
                    state_nxt = (out_done || out_last) ? ST_IDLE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_last) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            src        <= 1'b0;
            last_src   <= 1'b1;
            frame_done <= 1'b0;
            frame_src  <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            src        <= src_nxt;
            frame_done <= finish;
            if (finish) begin
                last_src  <= src;
                frame_src <= src;
            end
            if ((state == ST_IDLE) && filt_out_wr_en) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sobel_stream_arb.sv
// Directed bench for sobel_stream_arb with FIFO models and a ~3-cycle filter model.
module tb_sobel_stream_arb;
    import sobel_pkg::*;

    logic       clock;
    logic       reset;
    logic       in0_rd_en, in1_rd_en;
    logic [7:0] in0_dout, in1_dout;
    logic       in0_empty, in1_empty;
    logic       filt_in_rd_en;
    logic [7:0] filt_in_dout;
    logic       filt_in_empty;
    logic       filt_out_wr_en;
    logic [7:0] filt_out_din;
    logic       filt_out_full;
    logic       out0_wr_en, out1_wr_en;
    logic [7:0] out0_din, out1_din;
    logic       out0_full, out1_full;
    logic       src, busy, frame_done, frame_src, err;

    sobel_stream_arb #(
        .DWIDTH_IN(8), .DWIDTH_OUT(8), .IMG_WIDTH(4), .IMG_HEIGHT(3), .CNT_WIDTH(4)
    ) dut (
        .clock(clock), .reset(reset),
        .in0_rd_en(in0_rd_en), .in0_dout(in0_dout), .in0_empty(in0_empty),
        .in1_rd_en(in1_rd_en), .in1_dout(in1_dout), .in1_empty(in1_empty),
        .filt_in_rd_en(filt_in_rd_en), .filt_in_dout(filt_in_dout), .filt_in_empty(filt_in_empty),
        .filt_out_wr_en(filt_out_wr_en), .filt_out_din(filt_out_din), .filt_out_full(filt_out_full),
        .out0_wr_en(out0_wr_en), .out0_din(out0_din), .out0_full(out0_full),
        .out1_wr_en(out1_wr_en), .out1_din(out1_din), .out1_full(out1_full),
        .src(src), .busy(busy), .frame_done(frame_done), .frame_src(frame_src), .err(err)
    );

    typedef struct {
        int n0; int n1; bit tog;
        int e_rd0; int e_rd1; int e_wr0; int e_wr1; int e_frames; int e_seq;
    } vec_t;

    typedef struct { int rdy; logic [7:0] dat; } pend_t;

    int checks = 0;
    int errors = 0;

    // model state
    int in0_cnt, in1_cnt, in0_idx, in1_idx, o0_idx, o1_idx, cyc;
    bit in0_hide, tog0, fw_vld, force_wr;
    logic [7:0] fw_dat;
    pend_t pq[$];
    bit s_rd0, s_rd1, s_fr, s_fw;
    logic [7:0] s_fdat;
    // observation counters
    int rd0, rd1, wr0, wr1, frames, seq, viol, dchk, dbad;
    logic [1:0] prev_state;

    assign in0_empty      = (in0_cnt == 0) || in0_hide;
    assign in1_empty      = (in1_cnt == 0);
    assign in0_dout       = 8'(in0_idx);
    assign in1_dout       = 8'h80 + 8'(in1_idx);
    assign filt_in_rd_en  = !filt_in_empty;
    assign filt_out_wr_en = (fw_vld && !filt_out_full) || force_wr;
    assign filt_out_din   = fw_dat;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic sample();
        logic [7:0] e;
        if (in0_rd_en) begin
            rd0++;
            if (in0_empty || src || in1_rd_en) viol++;
        end
        if (in1_rd_en) begin
            rd1++;
            if (in1_empty || !src) viol++;
        end
        if (out0_wr_en) begin
            wr0++;
            if (out1_wr_en || src) viol++;
            e = ~8'(o0_idx);
            chk("out0_data", int'(out0_din), int'(e));
            o0_idx++;
        end
        if (out1_wr_en) begin
            wr1++;
            if (!src) viol++;
            e = ~(8'h80 + 8'(o1_idx));
            chk("out1_data", int'(out1_din), int'(e));
            o1_idx++;
        end
        if (frame_done) begin
            if (frames < 30) seq |= int'(frame_src) << frames;
            frames++;
        end
        if (dut.state == ST_DRAIN && prev_state == ST_STREAM) begin
            dchk++;
            if (int'(dut.u_in_cnt.cnt) != 12) dbad++;
        end
        prev_state = dut.state;
        s_rd0  = in0_rd_en;
        s_rd1  = in1_rd_en;
        s_fr   = filt_in_rd_en && !filt_in_empty;
        s_fdat = filt_in_dout;
        s_fw   = fw_vld && !filt_out_full;
    endtask

    task automatic apply();
        pend_t p;
        cyc++;
        if (reset) begin
            pq.delete();
            fw_vld = 1'b0;
            return;
        end
        if (s_rd0) begin in0_cnt--; in0_idx++; end
        if (s_rd1) begin in1_cnt--; in1_idx++; end
        if (s_fw && pq.size() > 0) pq.delete(0);
        if (s_fr) begin
            p.rdy = cyc + 3;
            p.dat = ~s_fdat;
            pq.push_back(p);
        end
        if (tog0) in0_hide = ~in0_hide;
        fw_vld = 1'b0;
        fw_dat = 8'h00;
        if (pq.size() > 0 && pq[0].rdy <= cyc) begin
            fw_vld = 1'b1;
            fw_dat = pq[0].dat;
        end
    endtask

    // Called and returns at a falling edge; samples just before the rising edge.
    task automatic tick();
        #4;
        sample();
        @(posedge clock);
        #1;
        apply();
        @(negedge clock);
    endtask

    task automatic start_scn(input int n0, input int n1, input bit tg);
        reset = 1'b1;
        in0_cnt = n0; in1_cnt = n1;
        in0_idx = 0; in1_idx = 0; o0_idx = 0; o1_idx = 0;
        in0_hide = 1'b0; tog0 = tg; force_wr = 1'b0;
        out0_full = 1'b0; out1_full = 1'b0;
        rd0 = 0; rd1 = 0; wr0 = 0; wr1 = 0; frames = 0; seq = 0;
        viol = 0; dchk = 0; dbad = 0; prev_state = ST_IDLE;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        int budget;
        budget = 0;
        while (frames < n && budget < 3000) begin
            tick();
            budget++;
        end
        if (frames < n) chk("frame_timeout", frames, n);
        repeat (10) tick();
    endtask

    vec_t vecs[4];
    int fullbad;

    initial begin
        vecs[0] = '{n0:12, n1:0,  tog:1'b0, e_rd0:12, e_rd1:0,  e_wr0:12, e_wr1:0,  e_frames:1, e_seq:0};
        vecs[1] = '{n0:24, n1:24, tog:1'b0, e_rd0:24, e_rd1:24, e_wr0:24, e_wr1:24, e_frames:4, e_seq:10};
        vecs[2] = '{n0:12, n1:0,  tog:1'b1, e_rd0:12, e_rd1:0,  e_wr0:12, e_wr1:0,  e_frames:1, e_seq:0};
        vecs[3] = '{n0:0,  n1:12, tog:1'b0, e_rd0:0,  e_rd1:12, e_wr0:0,  e_wr1:12, e_frames:1, e_seq:1};

        reset = 1'b1; cyc = 0; fw_vld = 1'b0; fw_dat = 8'h00; force_wr = 1'b0;
        in0_cnt = 0; in1_cnt = 0; in0_idx = 0; in1_idx = 0; tog0 = 1'b0; in0_hide = 1'b0;
        out0_full = 1'b0; out1_full = 1'b0;
        @(negedge clock);

        // reset state and combinational defaults
        chk("rst_busy", int'(busy), 0);
        chk("rst_src", int'(src), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_frame_src", int'(frame_src), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_filt_in_empty", int'(filt_in_empty), 1);
        chk("rst_filt_out_full", int'(filt_out_full), 1);
        chk("rst_strobes", int'({in0_rd_en, in1_rd_en, out0_wr_en, out1_wr_en}), 0);

        for (int i = 0; i < 4; i++) begin
            start_scn(vecs[i].n0, vecs[i].n1, vecs[i].tog);
            wait_frames(vecs[i].e_frames);
            chk($sformatf("v%0d_rd0", i), rd0, vecs[i].e_rd0);
            chk($sformatf("v%0d_rd1", i), rd1, vecs[i].e_rd1);
            chk($sformatf("v%0d_wr0", i), wr0, vecs[i].e_wr0);
            chk($sformatf("v%0d_wr1", i), wr1, vecs[i].e_wr1);
            chk($sformatf("v%0d_frames", i), frames, vecs[i].e_frames);
            chk($sformatf("v%0d_src_seq", i), seq, vecs[i].e_seq);
            chk($sformatf("v%0d_violations", i), viol, 0);
            chk($sformatf("v%0d_drain_seen", i), dchk, vecs[i].e_frames);
            chk($sformatf("v%0d_drain_in_cnt_bad", i), dbad, 0);
            chk($sformatf("v%0d_idle_busy", i), int'(busy), 0);
        end

        // output backpressure held through DRAIN
        start_scn(12, 0, 1'b0);
        for (int n = 0; n < 200 && dut.state != ST_DRAIN; n++) tick();
        chk("bp_reached_drain", int'(dut.state), int'(ST_DRAIN));
        out0_full = 1'b1;
        fullbad = 0;
        for (int n = 0; n < 10; n++) begin
            #1;
            if (!filt_out_full || out0_wr_en) fullbad++;
            tick();
        end
        chk("bp_full_cycles_bad", fullbad, 0);
        out0_full = 1'b0;
        wait_frames(1);
        chk("bp_wr0", wr0, 12);
        chk("bp_frames", frames, 1);
        chk("bp_viol", viol, 0);

        // stray filter write while idle
        start_scn(0, 0, 1'b0);
        chk("idle_err_before", int'(err), 0);
        force_wr = 1'b1;
        #1;
        chk("idle_wr_dropped", int'(out0_wr_en | out1_wr_en), 0);
        tick();
        force_wr = 1'b0;
        #1;
        chk("idle_err_set", int'(err), 1);
        repeat (5) tick();
        chk("idle_err_sticky", int'(err), 1);
        reset = 1'b1;
        #1;
        chk("idle_err_cleared", int'(err), 0);
        tick();
        reset = 1'b0;

        // reset mid-frame, then the next frame is granted to source 0 on a tie
        start_scn(12, 0, 1'b0);
        for (int n = 0; n < 200 && rd0 < 7; n++) tick();
        chk("mid_rd0", rd0, 7);
        reset = 1'b1;
        #1;
        chk("mid_busy", int'(busy), 0);
        chk("mid_state", int'(dut.state), int'(ST_IDLE));
        chk("mid_in_cnt", int'(dut.u_in_cnt.cnt), 0);
        chk("mid_out_cnt", int'(dut.u_out_cnt.cnt), 0);
        in0_cnt = 12; in1_cnt = 12; in0_idx = 0; in1_idx = 0; o0_idx = 0; o1_idx = 0;
        rd0 = 0; rd1 = 0; wr0 = 0; wr1 = 0; frames = 0; seq = 0; viol = 0;
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_busy", int'(busy), 1);
        chk("post_rst_src", int'(src), 0);
        chk("post_rst_first_read", int'(in0_rd_en), 1);
        wait_frames(1);
        chk("post_rst_frame_src", seq & 1, 0);
        chk("post_rst_wr0", wr0 >= 12 ? 12 : wr0, 12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
